hilo_mult_unit: RTL
===================

// Module: hilo_mult_unit
// PURPOSE
//  Multi-cycle unsigned multiplier with the architectural HI/LO register pair.
//  Sits directly downstream of the instruction decoder in the execute stage:
//  - writehilo (MULTU) starts a multiply of srca*srcb.
//  - loadhi/loadlo (MFHI/MFLO) select HI or LO onto the result mux.
//  - Drives stall back to the pipeline while a product is still being formed.
// PARAMETERS
//  WIDTH            32  operand width; product is 2*WIDTH bits split into HI/LO
//  BITS_PER_CYCLE    1  multiplier bits retired per RUN cycle; WIDTH % BITS_PER_CYCLE == 0
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset
//  writehilo  in   1      start request (MULTU in execute); qualified by stall
//  srca       in   WIDTH  multiplicand (rs)
//  srcb       in   WIDTH  multiplier (rt)
//  loadhi     in   1      MFHI in execute
//  loadlo     in   1      MFLO in execute
//  hilo_out   out  WIDTH  HI if loadhi, else LO (combinational)
//  busy       out  1      multiply in progress (state RUN)
//  stall      out  1      busy & (writehilo | loadhi | loadlo)
//  done       out  1      one-cycle pulse in the cycle after HI/LO are written
// BEHAVIOUR
//  Reset (reset==0, async): HI=0, LO=0, state=IDLE, count=0, busy=0, done=0;
//   internal multiplicand/multiplier/accumulator cleared.
//  - Reset mid-RUN aborts the multiply; no HI/LO update occurs.
//  Constants: N = WIDTH/BITS_PER_CYCLE.
//  States: IDLE, RUN.
//  IDLE:
//  - writehilo=1 -> latch srca into mcand and srcb into mplier, acc=0, count=N,
//    go to RUN.
//  - Else stay in IDLE.
//  RUN, each cycle:
//  - acc += (mplier[BITS_PER_CYCLE-1:0] * mcand) << shift.
//  - mplier >>= BITS_PER_CYCLE; shift += BITS_PER_CYCLE; count--.
//  - Arithmetic is unsigned; the accumulator is 2*WIDTH bits and never overflows.
//  - When count reaches 1, the same edge writes {HI,LO} = final acc and goes to IDLE.
//  - done=1 for the following single cycle.
//  Latency: start accepted at edge E; HI/LO hold the product after edge E+N.
//   An MFHI/MFLO issued in the cycle after that edge reads the new value.
//  busy=1 exactly for the N cycles spent in RUN.
//  Stall rules:
//  - writehilo while busy: not accepted. Stall holds the pipeline and the
//    request is re-presented, then accepted in the first IDLE cycle.
//  - loadhi/loadlo while busy: stall=1. hilo_out shows the old HI/LO (don't-use).
//  - Last RUN cycle: busy is still 1, so a new request stalls one more cycle.
//  hilo_out selection:
//  - loadhi and loadlo both 1: HI has priority.
//  - Both 0: LO is driven.
//  HI/LO are never changed by any input other than a completed multiply.
//  srca/srcb changes during RUN have no effect (operands are latched).
//  Product is 2*WIDTH bits; no truncation. Zero operands still take N cycles.
// TESTING
//  1) reset=0 then release; srca=3, srcb=5, writehilo 1 cycle
//     -> busy high 32 cycles; HI=0x00000000, LO=0x0000000F; done pulses once.
//  2) srca=0xFFFFFFFF, srcb=0xFFFFFFFF
//     -> HI=0xFFFFFFFE, LO=0x00000001 after 32 cycles.
//  3) Start 0x00010000*0x00010000, then hold loadlo at cycle 2
//     -> stall=1 through the RUN cycles; then hilo_out=0x00000000.
//     -> With loadhi instead: hilo_out=0x00000001.
//  4) Start 7*9; drive reset low at RUN cycle 10
//     -> HI=LO=0, busy=0 immediately (async); no done pulse.
//  5) Back-to-back: writehilo held high across the end of the first multiply
//     -> second product accepted only in the first IDLE cycle; both products correct.
//  6) BITS_PER_CYCLE=4: 0x12345678*0x9ABCDEF0
//     -> busy 8 cycles; {HI,LO}=0x0B00EA4E_242D2080.

Source files
------------

// File: rtl/hilo_mult_if.sv
// Execute-stage bundle between the pipeline and the HI/LO multiply unit:
// start/read requests from the decoder and the result and stall signals back to it.
interface hilo_mult_if #(
   parameter int WIDTH = 32
);
   logic             writehilo;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             loadhi;
   logic             loadlo;
   logic [WIDTH-1:0] hilo_out;
   logic             busy;
   logic             stall;
   logic             done;

   modport master (
      output writehilo, srca, srcb, loadhi, loadlo,
      input  hilo_out, busy, stall, done
   );

   modport slave (
      input  writehilo, srca, srcb, loadhi, loadlo,
      output hilo_out, busy, stall, done
   );
endinterface

// File: rtl/hilo_mult_unit.sv
// Multi-cycle unsigned shift-add multiplier owning the architectural HI/LO pair;
// retires BITS_PER_CYCLE multiplier bits per cycle and stalls the pipeline meanwhile.
module hilo_mult_unit #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic        clk,
   input logic        reset,
   hilo_mult_if.slave bus
);
   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   localparam int SW = $clog2(2 * WIDTH) + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state, stateNext;
   logic [WIDTH-1:0]   hi, lo;
   logic [WIDTH-1:0]   mcand, mplier;
   logic [2*WIDTH-1:0] acc, accNext, partial;
   logic [CW-1:0]      count;
   logic [SW-1:0]      shift;
   logic               doneReg;
   logic               startReq, lastCycle;

   // Partial product of the low multiplier digit, placed at the current weight.
   always_comb begin
      partial   = {{WIDTH{1'b0}}, mcand} *
                  {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
      accNext   = acc + (partial << shift);
      startReq  = (state == IDLE) && bus.writehilo;
      lastCycle = (state == RUN) && (count == CW'(1));
   end

   // Next-state logic: a start leaves IDLE, the final digit returns to it.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (startReq)  stateNext = RUN;
         RUN:  if (lastCycle) stateNext = IDLE;
         default:             stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         hi      <= '0;
         lo      <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         count   <= '0;
         shift   <= '0;
         doneReg <= 1'b0;
      end else begin
         state   <= stateNext;
         doneReg <= lastCycle;
         if (startReq) begin
            mcand  <= bus.srca;
            mplier <= bus.srcb;
            acc    <= '0;
            count  <= CW'(N);
            shift  <= '0;
         end else if (state == RUN) begin
            acc    <= accNext;
            mplier <= mplier >> BITS_PER_CYCLE;
            shift  <= shift + SW'(BITS_PER_CYCLE);
            count  <= count - CW'(1);
            // HI/LO change only here, on the edge that retires the last digit.
            if (lastCycle) {hi, lo} <= accNext;
         end
      end
   end

   always_comb begin
      bus.busy     = (state == RUN);
      bus.stall    = bus.busy & (bus.writehilo | bus.loadhi | bus.loadlo);
      bus.done     = doneReg;
      bus.hilo_out = bus.loadhi ? hi : lo;
   end
endmodule
